// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: scan sequencer for a 16:1 x 8-bit mux.
// Walks the mux select through the channels enabled in CH_MASK in ascending
// order, waits SETTLE_CYC cycles on each channel, captures the mux output and
// presents it downstream on a valid/ready handshake tagged with its channel.
// Supports single-pass and continuous (wrap-around) scans with a sticky stop.
//
// Optional feature, macro SCAN_MAX_TRACK_EN: adds max_data/max_ch outputs that
// track the largest sample of the current scan (ties keep the earlier channel).
module mux_scan_ctrl #(
  parameter int          SETTLE_CYC = 1,        // legal range 1..15
  parameter logic [15:0] CH_MASK    = 16'hFFFF  // bit i enables channel i
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  input  logic       stop,
  output logic       sel3,
  output logic       sel2,
  output logic       sel1,
  output logic       sel0,
  input  logic [7:0] mux_data,
  output logic [7:0] out_data,
  output logic [3:0] out_ch,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       done
`ifdef SCAN_MAX_TRACK_EN
  ,
  output logic [7:0] max_data,
  output logic [3:0] max_ch
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_RELOAD = 4'(SETTLE_CYC - 1);
  localparam bit         MASK_EMPTY = (CH_MASK == 16'h0000);

  state_t     state_q, state_d;
  logic [3:0] sel_q, sel_d;
  logic [3:0] cnt_q, cnt_d;
  logic       cont_q, cont_d;
  logic       stop_q, stop_d;
  logic [7:0] data_q, data_d;
  logic [3:0] ch_q, ch_d;
  logic       valid_q, valid_d;
  logic       done_q, done_d;

`ifdef SCAN_MAX_TRACK_EN
  logic [7:0] max_data_q, max_data_d;
  logic [3:0] max_ch_q, max_ch_d;
  logic       first_q, first_d;
`endif

  logic [3:0] first_ch;
  logic [3:0] next_ch;
  logic       has_next;
  logic       stop_seen;

  // Lowest enabled channel overall, and lowest enabled channel above sel_q.
  always_comb begin
    first_ch = 4'd0;
    next_ch  = 4'd0;
    has_next = 1'b0;
    // Descending walk: the last hit is the lowest qualifying channel.
    for (int i = 15; i >= 0; i--) begin
      if (CH_MASK[i]) begin
        first_ch = 4'(i);
        if (4'(i) > sel_q) begin
          has_next = 1'b1;
          next_ch  = 4'(i);
        end
      end
    end
  end

  assign stop_seen = stop_q | stop;

  // Next-state and datapath decode for the scan FSM.
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    cont_d  = cont_q;
    stop_d  = stop_q;
    data_d  = data_q;
    ch_d    = ch_q;
    valid_d = valid_q;
    done_d  = 1'b0;
`ifdef SCAN_MAX_TRACK_EN
    max_data_d = max_data_q;
    max_ch_d   = max_ch_q;
    first_d    = first_q;
`endif

    unique case (state_q)
      IDLE: begin
        stop_d = 1'b0;
        if (start) begin
          if (!MASK_EMPTY) begin
            // A stop arriving together with start still counts for this scan.
            cont_d  = cont;
            stop_d  = stop;
            sel_d   = first_ch;
            cnt_d   = CNT_RELOAD;
            state_d = SETTLE;
`ifdef SCAN_MAX_TRACK_EN
            max_data_d = 8'h00;
            max_ch_d   = 4'h0;
            first_d    = 1'b1;
`endif
          end else begin
            done_d = 1'b1;
          end
        end
      end

      SETTLE: begin
        stop_d = stop_seen;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          data_d  = mux_data;
          ch_d    = sel_q;
          valid_d = 1'b1;
          state_d = HOLD;
`ifdef SCAN_MAX_TRACK_EN
          if (first_q || (mux_data > max_data_q)) begin
            max_data_d = mux_data;
            max_ch_d   = sel_q;
          end
          first_d = 1'b0;
`endif
        end
      end

      HOLD: begin
        stop_d = stop_seen;
        if (out_ready) begin
          valid_d = 1'b0;
          if (!stop_seen && has_next) begin
            sel_d   = next_ch;
            cnt_d   = CNT_RELOAD;
            state_d = SETTLE;
          end else if (!stop_seen && cont_q) begin
            sel_d   = first_ch;
            cnt_d   = CNT_RELOAD;
            state_d = SETTLE;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any pending sample.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register here is a plain flop with a defined reset value;
    // non-blocking assignments keep all of them updating from pre-edge values.
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 4'd0;
      cnt_q   <= 4'd0;
      cont_q  <= 1'b0;
      stop_q  <= 1'b0;
      data_q  <= 8'h00;
      ch_q    <= 4'd0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      cont_q  <= cont_d;
      stop_q  <= stop_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

`ifdef SCAN_MAX_TRACK_EN
  // Running maximum of the current scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_data_q <= 8'h00;
      max_ch_q   <= 4'd0;
      first_q    <= 1'b0;
    end else begin
      max_data_q <= max_data_d;
      max_ch_q   <= max_ch_d;
      first_q    <= first_d;
    end
  end

  assign max_data = max_data_q;
  assign max_ch   = max_ch_q;
`endif

  assign sel3      = sel_q[3];
  assign sel2      = sel_q[2];
  assign sel1      = sel_q[1];
  assign sel0      = sel_q[0];
  assign out_data  = data_q;
  assign out_ch    = ch_q;
  assign out_valid = valid_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl. Five instances cover the parameter
// sets needed (mask FFFF/8421/0003/0000/000F); a scoreboard queue holds the
// expected {channel, data} of every sample and a monitor pops it on each
// accepted handshake of the instance under test.
module tb_mux_scan_ctrl;

  typedef struct packed {
    logic [3:0] ch;
    logic [7:0] data;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic [4:0]      start_r, cont_r, stop_r, ready_r;
  logic [4:0][3:0] sel_w;
  logic [4:0][7:0] mux_w;
  logic [4:0][7:0] out_data_w;
  logic [4:0][3:0] out_ch_w;
  logic [4:0]      out_valid_w, busy_w, done_w;
`ifdef SCAN_MAX_TRACK_EN
  logic [4:0][7:0] max_w;
  logic [4:0][3:0] max_ch_w;
`endif

  exp_t sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   act      = 0;
  int   gap      = 0;
  int   last_t   = -1;
  int   cyc      = 0;

  function automatic logic [7:0] model6(input logic [3:0] s);
    case (s)
      4'd0:    return 8'h10;
      4'd1:    return 8'h50;
      4'd2:    return 8'h50;
      4'd3:    return 8'h20;
      default: return 8'h00;
    endcase
  endfunction

  for (genvar g = 0; g < 5; g++) begin : g_dut
    localparam int          SC = (g == 1) ? 3 : 1;
    localparam logic [15:0] MK = (g == 0) ? 16'hFFFF :
                                 (g == 1) ? 16'h8421 :
                                 (g == 2) ? 16'h0003 :
                                 (g == 3) ? 16'h0000 : 16'h000F;
    assign mux_w[g] = (g == 4) ? model6(sel_w[g]) : (8'hA0 + {4'h0, sel_w[g]});

    mux_scan_ctrl #(.SETTLE_CYC(SC), .CH_MASK(MK)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start_r[g]),
      .cont     (cont_r[g]),
      .stop     (stop_r[g]),
      .sel3     (sel_w[g][3]),
      .sel2     (sel_w[g][2]),
      .sel1     (sel_w[g][1]),
      .sel0     (sel_w[g][0]),
      .mux_data (mux_w[g]),
      .out_data (out_data_w[g]),
      .out_ch   (out_ch_w[g]),
      .out_valid(out_valid_w[g]),
      .out_ready(ready_r[g]),
      .busy     (busy_w[g]),
      .done     (done_w[g])
`ifdef SCAN_MAX_TRACK_EN
      ,
      .max_data (max_w[g]),
      .max_ch   (max_ch_w[g])
`endif
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: pops one expected sample per accepted handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid_w[act] && ready_r[act]) begin
      if (sb_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $error("FAIL unexpected_sample: observed ch %0d data %0h expected none",
               out_ch_w[act], out_data_w[act]);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sample_ch", 32'(out_ch_w[act]), 32'(e.ch));
        chk("sample_data", 32'(out_data_w[act]), 32'(e.data));
      end
      if (gap != 0 && last_t >= 0) chk("sample_gap", cyc - last_t, gap);
      last_t = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch, input logic [7:0] d);
    exp_t e;
    e.ch   = 4'(ch);
    e.data = d;
    sb_q.push_back(e);
  endtask

  task automatic push_full();
    for (int c = 0; c < 16; c++) push(c, 8'(8'hA0 + c));
  endtask

  // Start sampled at the posedge inside the second tick.
  task automatic pulse_start(input int g, input logic c, input logic s);
    tick();
    start_r[g] = 1'b1;
    cont_r[g]  = c;
    stop_r[g]  = s;
    tick();
    start_r[g] = 1'b0;
    cont_r[g]  = 1'b0;
    stop_r[g]  = 1'b0;
  endtask

  task automatic wait_done(input int g, input int budget);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    while (!got && n < budget) begin
      @(negedge clk);
      if (done_w[g]) got = 1'b1;
      n++;
    end
    chk($sformatf("done_seen_g%0d", g), 32'(got), 32'd1);
    chk($sformatf("busy_at_done_g%0d", g), 32'(busy_w[g]), 32'd0);
  endtask

  task automatic wait_settle(input int g, input logic [3:0] ch, input int budget);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    while (!got && n < budget) begin
      @(negedge clk);
      if (sel_w[g] == ch && !out_valid_w[g]) got = 1'b1;
      n++;
    end
    chk($sformatf("reach_settle_ch%0d", ch), 32'(got), 32'd1);
  endtask

  initial begin
    int cnt;
    int n;
    rst_n   = 1'b0;
    start_r = '0;
    cont_r  = '0;
    stop_r  = '0;
    ready_r = '0;
    #7;
    // Reset values.
    chk("rst_sel", 32'(sel_w[0]), 32'd0);
    chk("rst_valid", 32'(out_valid_w[0]), 32'd0);
    chk("rst_data", 32'(out_data_w[0]), 32'd0);
    chk("rst_ch", 32'(out_ch_w[0]), 32'd0);
    chk("rst_busy", 32'(busy_w[0]), 32'd0);
    chk("rst_done", 32'(done_w[0]), 32'd0);
    #5 rst_n = 1'b1;

    // 1: full single-pass scan, SETTLE_CYC=1, spacing 2 cycles.
    act = 0; gap = 2; last_t = -1;
    ready_r[0] = 1'b1;
    push_full();
    pulse_start(0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t1_busy", 32'(busy_w[0]), 32'd1);
    chk("t1_valid_k", 32'(out_valid_w[0]), 32'd0);
    @(negedge clk);
    chk("t1_valid_k1", 32'(out_valid_w[0]), 32'd1);
    chk("t1_first_ch", 32'(out_ch_w[0]), 32'd0);
    wait_done(0, 60);
    chk("t1_sb_empty", sb_q.size(), 0);
    @(negedge clk);
    chk("t1_done_pulse", 32'(done_w[0]), 32'd0);
    chk("t1_sel_kept", 32'(sel_w[0]), 32'd15);

    // 2: sparse mask 8421, SETTLE_CYC=3; sel held 3 cycles per channel.
    act = 1; gap = 4; last_t = -1;
    ready_r[1] = 1'b1;
    for (int j = 0; j < 4; j++) push(j * 5, 8'(8'hA0 + j * 5));
    pulse_start(1, 1'b0, 1'b0);
    for (int j = 0; j < 4; j++) begin
      n = 0;
      @(negedge clk);
      while (!out_valid_w[1] && n < 10) begin
        chk("t2_settle_sel", 32'(sel_w[1]), 32'(j * 5));
        n++;
        @(negedge clk);
      end
      chk("t2_settle_len", n, 3);
    end
    wait_done(1, 20);
    chk("t2_sb_empty", sb_q.size(), 0);

    // 3: backpressure on ch2 for 5 cycles.
    act = 0; gap = 0; last_t = -1;
    push_full();
    pulse_start(0, 1'b0, 1'b0);
    wait_settle(0, 4'd2, 40);
    tick();
    ready_r[0] = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("t3_hold_valid", 32'(out_valid_w[0]), 32'd1);
      chk("t3_hold_data", 32'(out_data_w[0]), 32'hA2);
      chk("t3_hold_sel", 32'(sel_w[0]), 32'd2);
    end
    chk("t3_hold_ch", 32'(out_ch_w[0]), 32'd2);
    tick();
    ready_r[0] = 1'b1;
    @(negedge clk);
    chk("t3_sel_before_accept", 32'(sel_w[0]), 32'd2);
    @(negedge clk);
    chk("t3_sel_next", 32'(sel_w[0]), 32'd3);
    chk("t3_valid_drop", 32'(out_valid_w[0]), 32'd0);
    wait_done(0, 60);
    chk("t3_sb_empty", sb_q.size(), 0);

    // 4: continuous two-channel scan, stop during ch1 HOLD.
    act = 2; gap = 0; last_t = -1;
    ready_r[2] = 1'b1;
    for (int j = 0; j < 3; j++) begin
      push(0, 8'hA0);
      push(1, 8'hA1);
    end
    pulse_start(2, 1'b1, 1'b0);
    cnt = 0; n = 0;
    while (cnt < 3 && n < 40) begin
      @(negedge clk);
      if (sel_w[2] == 4'd1 && !out_valid_w[2]) cnt++;
      n++;
    end
    chk("t4_rounds", cnt, 3);
    tick();
    ready_r[2] = 1'b0;
    stop_r[2]  = 1'b1;
    tick();
    stop_r[2]  = 1'b0;
    @(negedge clk);
    chk("t4_hold_ch1", 32'(out_ch_w[2]), 32'd1);
    chk("t4_hold_valid", 32'(out_valid_w[2]), 32'd1);
    tick();
    ready_r[2] = 1'b1;
    wait_done(2, 5);
    chk("t4_sb_empty", sb_q.size(), 0);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("t4_idle_valid", 32'(out_valid_w[2]), 32'd0);
    end

    // 5: asynchronous reset during SETTLE of ch7, then a fresh scan.
    act = 0; gap = 2; last_t = -1;
    push_full();
    pulse_start(0, 1'b0, 1'b0);
    wait_settle(0, 4'd7, 40);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_sel", 32'(sel_w[0]), 32'd0);
    chk("t5_rst_valid", 32'(out_valid_w[0]), 32'd0);
    chk("t5_rst_data", 32'(out_data_w[0]), 32'd0);
    chk("t5_rst_ch", 32'(out_ch_w[0]), 32'd0);
    chk("t5_rst_busy", 32'(busy_w[0]), 32'd0);
    sb_q.delete();
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("t5_rst_done", 32'(done_w[0]), 32'd0);
    end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_post_done", 32'(done_w[0]), 32'd0);
    last_t = -1;
    push_full();
    pulse_start(0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("t5_restart_ch", 32'(out_ch_w[0]), 32'd0);
    wait_done(0, 60);
    chk("t5_sb_empty", sb_q.size(), 0);

    // 5b: empty mask gives a lone done pulse.
    act = 3; gap = 0; last_t = -1;
    ready_r[3] = 1'b1;
    pulse_start(3, 1'b0, 1'b0);
    @(negedge clk);
    chk("t5b_done", 32'(done_w[3]), 32'd1);
    chk("t5b_busy", 32'(busy_w[3]), 32'd0);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("t5b_done_off", 32'(done_w[3]), 32'd0);
      chk("t5b_valid", 32'(out_valid_w[3]), 32'd0);
    end

`ifdef SCAN_MAX_TRACK_EN
    // 6: max tracking with a tie between ch1 and ch2.
    act = 4; gap = 2; last_t = -1;
    ready_r[4] = 1'b1;
    chk("t6_rst_max", 32'(max_w[4]), 32'd0);
    chk("t6_rst_max_ch", 32'(max_ch_w[4]), 32'd0);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) push(c, model6(4'(c)));
      last_t = -1;
      pulse_start(4, 1'b0, 1'b0);
      @(negedge clk);
      chk("t6_cleared", 32'(max_w[4]), 32'd0);
      wait_done(4, 30);
      chk("t6_max_data", 32'(max_w[4]), 32'h50);
      chk("t6_max_ch", 32'(max_ch_w[4]), 32'd1);
      repeat (3) @(negedge clk);
      chk("t6_max_held", 32'(max_w[4]), 32'h50);
    end
    chk("t6_sb_empty", sb_q.size(), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
Sequencer placed directly upstream of the 16:1 8-bit mux. It drives the mux's four select bits through the enabled channels in ascending order and waits a programmable settle time on each channel. It then captures the mux output and hands each sample downstream over a valid/ready handshake, tagged with its channel number. It supports single-pass and continuous (wrap-around) scanning.

Parameters:
SETTLE_CYC, 1, cycles each channel is held selected before capture; legal range 1..15.
CH_MASK, 16'hFFFF, bit i = 1 enables channel i; disabled channels are skipped.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  begin a scan; sampled only in IDLE.
cont  input  1  continuous mode; sampled together with start.
stop  input  1  end a continuous scan after the current sample is accepted.
sel3  output  1  mux select bit 3 (MSB).
sel2  output  1  mux select bit 2.
sel1  output  1  mux select bit 1.
sel0  output  1  mux select bit 0 (LSB).
mux_data  input  8  combinational output of the 16:1 mux.
out_data  output  8  captured sample.
out_ch  output  4  channel of out_data.
out_valid  output  1  sample available.
out_ready  input  1  downstream accepts the sample.
busy  output  1  high whenever the state is not IDLE.
done  output  1  one-cycle pulse when a scan finishes.

Behaviour:
- Clocking: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state IDLE. sel3..sel0, out_data, out_ch, out_valid, busy, done and the settle counter are all 0.
- States: IDLE, SETTLE, HOLD.
- IDLE:
  - start=1 with CH_MASK != 0: latch cont; sel <= lowest enabled channel; cnt <= SETTLE_CYC-1; go to SETTLE.
  - start=1 with CH_MASK == 0: pulse done for one cycle, stay IDLE, produce no samples.
- SETTLE: sel is held constant.
  - cnt != 0: cnt decrements.
  - cnt == 0: out_data <= mux_data, out_ch <= sel, out_valid <= 1; go to HOLD.
- HOLD: out_valid, out_data and out_ch are held stable until out_ready=1. Sel is not changed.
- On acceptance (out_valid & out_ready at an edge): out_valid <= 0 at that edge, then one of:
  - a higher enabled channel exists: sel <= next enabled channel, cnt reloaded, go to SETTLE.
  - no higher enabled channel, latched cont=1, and stop not seen: wrap; sel <= lowest enabled channel, go to SETTLE.
  - otherwise: done=1 for one cycle, go to IDLE. sel keeps its last value.
- Latency: the edge that samples start is edge k. The first capture happens at edge k+SETTLE_CYC. out_valid is high from then on. With out_ready held at 1, channels are spaced SETTLE_CYC+1 cycles apart.
- stop handling:
  - stop is sticky: any cycle high while busy sets a stop flag. The flag clears in IDLE.
  - The current sample still completes. In continuous mode the scan ends at the next acceptance.
  - In single-pass mode stop ends the scan at the next acceptance, with no further channels.
- start while busy is ignored. cont changes while busy are ignored.
- Simultaneous start and stop in IDLE: start wins. The scan begins with the stop flag already set, so exactly one sample is produced.
- A single enabled channel with cont=1 re-samples that channel each round.
- Reset mid-operation: everything returns to reset values immediately. Any pending sample is discarded with no done pulse.

Optional Feature:
SCAN_MAX_TRACK_EN:
- Defined: adds outputs max_data[7:0] and max_ch[3:0]. Both are reset to 0 and cleared to 0 when a scan starts.
- At each capture, if mux_data > max_data (unsigned, strict) or this is the first capture of the scan, both are updated. Ties keep the earlier channel.
- Values are held after done until the next start.
- Undefined: the ports and logic are absent. The rest of the behaviour is identical.

Test Plan:
Mux model mux_data = 8'hA0 + sel.
1. SETTLE_CYC=1, CH_MASK=FFFF, cont=0, out_ready=1, start pulse -> 16 samples A0..AF with out_ch 0..15, spaced 2 cycles apart; first out_valid 1 cycle after start edge; one done pulse after ch15; busy then 0.
2. CH_MASK=16'h8421, SETTLE_CYC=3 -> exactly samples A0/ch0, A5/ch5, AA/ch10, AF/ch15; sel is held stable for 3 cycles before each capture.
3. out_ready held low for 5 cycles on ch2 -> out_valid stays 1 with out_data=A2 stable and sel=2 unchanged; the ch3 select occurs only after out_ready rises.
4. cont=1, CH_MASK=16'h0003, stop pulsed while ch1 is in HOLD -> sequence 0,1,0,1,... until stop; ch1 is accepted, then done, IDLE; no further ch0 sample.
5. rst_n driven low during SETTLE of ch7 -> all outputs 0 asynchronously with no done pulse; after release, a new start scans from ch0. CH_MASK=0 with start -> done pulse only, out_valid never asserted.
6. With SCAN_MAX_TRACK_EN defined, mux model returns 8'h10, 8'h50, 8'h50, 8'h20 for ch0..3, CH_MASK=000F -> max_data=8'h50, max_ch=1.
